// File: rtl/miner_pkg.sv
// Shared definitions for the miner datapath: work-unit geometry and loader FSM states.
package miner_pkg;

  localparam int WORK_BYTES = 44;
  localparam int MIDSTATE_W = 256;
  localparam int DATA2_W    = 96;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

endpackage

// File: rtl/work_loader.sv
// Assembles 44-byte work units (midstate + data2 tail) from a UART byte stream,
// commits them to the miner core and drops partial frames after an inter-byte gap.
module work_loader
  import miner_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [MIDSTATE_W-1:0] midstate,
  output logic [DATA2_W-1:0]    data2,
  output logic                  start_mining,
  output logic                  frame_drop,
  output logic                  loading,
  output logic [7:0]            work_count
);

  localparam int FRAME_W = MIDSTATE_W + DATA2_W;
  // Only the first 43 bytes need storage; the 44th is taken straight from rx_data at commit.
  localparam int HOLD_W = FRAME_W - 8;
  localparam logic [5:0] LAST_BYTE = 6'(WORK_BYTES - 1);

  state_e                  state_q, state_d;
  logic [5:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             gap_q, gap_d;
  logic [HOLD_W-1:0]       sr_q, sr_d;
  logic [MIDSTATE_W-1:0]   midstate_q, midstate_d;
  logic [DATA2_W-1:0]      data2_q, data2_d;
  logic                    start_q, start_d;
  logic                    drop_q, drop_d;
  logic [7:0]              work_count_q, work_count_d;
  logic [FRAME_W-1:0]      sr_shift;

  assign sr_shift = {sr_q, rx_data};

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    gap_d        = gap_q;
    sr_d         = sr_q;
    midstate_d   = midstate_q;
    data2_d      = data2_q;
    start_d      = 1'b0;
    drop_d       = 1'b0;
    work_count_d = work_count_q;
    case (state_q)
      ST_IDLE: begin
        byte_cnt_d = '0;
        gap_d      = '0;
        if (rx_valid) begin
          sr_d       = sr_shift[HOLD_W-1:0];
          byte_cnt_d = 6'd1;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          sr_d  = sr_shift[HOLD_W-1:0];
          gap_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            midstate_d   = sr_shift[FRAME_W-1:DATA2_W];
            data2_d      = sr_shift[DATA2_W-1:0];
            start_d      = 1'b1;
            work_count_d = work_count_q + 8'd1;
            byte_cnt_d   = '0;
            state_d      = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end else if (gap_q == TIMEOUT_CYCLES - 32'd1) begin
          // A byte in the expiring cycle wins, so the drop only happens on a truly idle cycle.
          drop_d     = 1'b1;
          byte_cnt_d = '0;
          gap_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      gap_q        <= '0;
      sr_q         <= '0;
      midstate_q   <= '0;
      data2_q      <= '0;
      start_q      <= 1'b0;
      drop_q       <= 1'b0;
      work_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_q        <= gap_d;
      sr_q         <= sr_d;
      midstate_q   <= midstate_d;
      data2_q      <= data2_d;
      start_q      <= start_d;
      drop_q       <= drop_d;
      work_count_q <= work_count_d;
    end
  end

  assign midstate     = midstate_q;
  assign data2        = data2_q;
  assign start_mining = start_q;
  assign frame_drop   = drop_q;
  assign loading      = (state_q == ST_RECV);
  assign work_count   = work_count_q;

endmodule

// File: tb/tb_work_loader.sv
// Randomised self-checking bench for work_loader against a byte-queue reference model.
module tb_work_loader;

  localparam logic [31:0] TMO = 32'd16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic         start_mining;
  logic         frame_drop;
  logic         loading;
  logic [7:0]   work_count;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes of the frame in progress plus idle cycles since the last byte.
  byte unsigned frame_q[$];
  int           gap = 0;
  logic [255:0] exp_mid = '0;
  logic [95:0]  exp_d2 = '0;
  logic [7:0]   exp_wc = '0;
  logic         exp_start = 1'b0;
  logic         exp_drop = 1'b0;
  int           exp_starts = 0;
  int           exp_drops = 0;
  int           start_seen = 0;
  int           drop_seen = 0;

  work_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .midstate     (midstate),
    .data2        (data2),
    .start_mining (start_mining),
    .frame_drop   (frame_drop),
    .loading      (loading),
    .work_count   (work_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start_mining) start_seen++;
      if (frame_drop) drop_seen++;
    end
  end

  // One clock of stimulus; afterwards the model holds what the outputs should show.
  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    exp_start = 1'b0;
    exp_drop  = 1'b0;
    if (v) begin
      frame_q.push_back(d);
      gap = 0;
      if (frame_q.size() == 44) begin
        for (int i = 0; i < 32; i++) exp_mid[255-8*i -: 8] = frame_q[i];
        for (int i = 0; i < 12; i++) exp_d2[95-8*i -: 8] = frame_q[32+i];
        exp_wc = exp_wc + 8'd1;
        exp_start = 1'b1;
        exp_starts++;
        frame_q.delete();
        $display("commit: work_count=%0d midstate[255:248]=%02h data2[7:0]=%02h",
                 exp_wc, exp_mid[255:248], exp_d2[7:0]);
      end
    end else if (frame_q.size() > 0) begin
      gap++;
      if (gap == int'(TMO)) begin
        exp_drop = 1'b1;
        exp_drops++;
        $display("drop: %0d partial bytes discarded", frame_q.size());
        frame_q.delete();
        gap = 0;
      end
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame_q.delete();
    gap = 0;
    exp_mid = '0;
    exp_d2 = '0;
    exp_wc = '0;
    exp_start = 1'b0;
    exp_drop = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (midstate !== 256'd0 || data2 !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: midstate=%h data2=%h required 0", midstate, data2);
    end
    checks++;
    if (start_mining !== 1'b0 || frame_drop !== 1'b0 || loading !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: start=%b drop=%b loading=%b required 000",
               start_mining, frame_drop, loading);
    end
    checks++;
    if (work_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: work_count=%0d required 0", work_count);
    end
  endtask

  task automatic test_single_frame();
    for (int b = 0; b < 44; b++) begin
      cycle(1'b1, 8'(b));
      if (b == 0) begin
        checks++;
        if (loading !== 1'b1) begin
          errors++;
          $display("FAIL single_loading_rise: loading=%b required 1", loading);
        end
      end
    end
    checks++;
    if (start_mining !== 1'b1) begin
      errors++;
      $display("FAIL single_start: start_mining=%b required 1", start_mining);
    end
    checks++;
    if (midstate[255:248] !== 8'h00 || midstate[7:0] !== 8'h1F ||
        data2[95:88] !== 8'h20 || data2[7:0] !== 8'h2B) begin
      errors++;
      $display("FAIL single_order: ms_hi=%02h ms_lo=%02h d2_hi=%02h d2_lo=%02h required 00 1f 20 2b",
               midstate[255:248], midstate[7:0], data2[95:88], data2[7:0]);
    end
    checks++;
    if (midstate !== exp_mid || data2 !== exp_d2) begin
      errors++;
      $display("FAIL single_frame: midstate=%h data2=%h required %h %h", midstate, data2, exp_mid, exp_d2);
    end
    checks++;
    if (work_count !== 8'd1) begin
      errors++;
      $display("FAIL single_count: work_count=%0d required 1", work_count);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (start_mining !== 1'b0 || loading !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_end: start=%b loading=%b required 0 0", start_mining, loading);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 10;
    for (int i = 0; i < n; i++) cycle(1'b1, 8'($urandom));
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00);
    checks++;
    if (frame_drop !== 1'b0 || loading !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: drop=%b loading=%b required 0 1", frame_drop, loading);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (frame_drop !== exp_drop || frame_drop !== 1'b1 || loading !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: drop=%b loading=%b required 1 0", frame_drop, loading);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (frame_drop !== 1'b0 || start_mining !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: drop=%b start=%b required 0 0", frame_drop, start_mining);
    end
    checks++;
    if (midstate !== exp_mid || data2 !== exp_d2) begin
      errors++;
      $display("FAIL timeout_hold: midstate=%h data2=%h required %h %h", midstate, data2, exp_mid, exp_d2);
    end
    for (int i = 0; i < 44; i++) cycle(1'b1, 8'hAA);
    checks++;
    if (midstate !== {32{8'hAA}} || data2 !== {12{8'hAA}} || work_count !== exp_wc) begin
      errors++;
      $display("FAIL timeout_recover: midstate=%h data2=%h count=%0d required all aa count=%0d",
               midstate, data2, work_count, exp_wc);
    end
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    checks++;
    if (drop_seen !== exp_drops || start_seen !== exp_starts) begin
      errors++;
      $display("FAIL timeout_pulses: drops=%0d starts=%0d required %0d %0d",
               drop_seen, start_seen, exp_drops, exp_starts);
    end
  endtask

  task automatic test_timeout_race();
    int n;
    n = $urandom_range(40, 1);
    for (int i = 0; i < n; i++) cycle(1'b1, 8'($urandom));
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'($urandom));
    checks++;
    if (frame_drop !== 1'b0 || loading !== 1'b1) begin
      errors++;
      $display("FAIL race_accept: drop=%b loading=%b required 0 1", frame_drop, loading);
    end
    for (int i = n + 1; i < 44; i++) cycle(1'b1, 8'($urandom));
    checks++;
    if (start_mining !== 1'b1 || midstate !== exp_mid || data2 !== exp_d2 || work_count !== exp_wc) begin
      errors++;
      $display("FAIL race_commit: start=%b midstate=%h data2=%h count=%0d required 1 %h %h %0d",
               start_mining, midstate, data2, work_count, exp_mid, exp_d2, exp_wc);
    end
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    checks++;
    if (drop_seen !== exp_drops || start_seen !== exp_starts) begin
      errors++;
      $display("FAIL race_pulses: drops=%0d starts=%0d required %0d %0d",
               drop_seen, start_seen, exp_drops, exp_starts);
    end
  endtask

  task automatic test_spaced();
    int drops0;
    int idle;
    drops0 = exp_drops;
    for (int i = 0; i < 44; i++) begin
      cycle(1'b1, 8'($urandom));
      idle = (i % 3 == 0) ? 15 : int'($urandom_range(15, 0));
      if (i < 43) for (int k = 0; k < idle; k++) cycle(1'b0, 8'h00);
    end
    checks++;
    if (start_mining !== 1'b1 || midstate !== exp_mid || data2 !== exp_d2) begin
      errors++;
      $display("FAIL spaced_commit: start=%b midstate=%h data2=%h required 1 %h %h",
               start_mining, midstate, data2, exp_mid, exp_d2);
    end
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    checks++;
    if (drop_seen !== drops0 || exp_drops !== drops0) begin
      errors++;
      $display("FAIL spaced_nodrop: drops=%0d required %0d", drop_seen, drops0);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom));
    do_reset();
    checks++;
    if (midstate !== 256'd0 || data2 !== 96'd0 || work_count !== 8'd0 ||
        loading !== 1'b0 || start_mining !== 1'b0 || frame_drop !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: midstate=%h data2=%h count=%0d loading=%b start=%b drop=%b required all 0",
               midstate, data2, work_count, loading, start_mining, frame_drop);
    end
    for (int i = 0; i < 44; i++) cycle(1'b1, 8'($urandom));
    checks++;
    if (start_mining !== 1'b1 || midstate !== exp_mid || data2 !== exp_d2 || work_count !== 8'd1) begin
      errors++;
      $display("FAIL midreset_frame: start=%b midstate=%h data2=%h count=%0d required 1 %h %h 1",
               start_mining, midstate, data2, work_count, exp_mid, exp_d2);
    end
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    checks++;
    if (drop_seen !== exp_drops) begin
      errors++;
      $display("FAIL midreset_nodrop: drops=%0d required %0d", drop_seen, exp_drops);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int starts0;
    do_reset();
    starts0 = start_seen;
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < 44; i++) cycle(1'b1, 8'($urandom));
      checks++;
      if (start_mining !== 1'b1 || midstate !== exp_mid || data2 !== exp_d2 || work_count !== exp_wc) begin
        errors++;
        $display("FAIL wrap_frame%0d: start=%b count=%0d midstate=%h required 1 %0d %h",
                 f, start_mining, work_count, midstate, exp_wc, exp_mid);
      end
    end
    checks++;
    if (work_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_count: work_count=%0d required 1", work_count);
    end
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    checks++;
    if (start_seen - starts0 !== 257) begin
      errors++;
      $display("FAIL wrap_pulses: starts=%0d required 257", start_seen - starts0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_timeout();
    test_timeout_race();
    test_spaced();
    test_reset_mid_frame();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
